el_request_scheduler: RTL and testbench

- Sequencing controller for the 3-floor elevator car.
- Latches cab and hall calls into pending registers and tracks car position from the floor sensors.
- Selects travel direction with a SCAN policy: keep going while calls lie ahead, otherwise reverse.
- Drives the motor command, floor display and door, and times the door-open dwell.

---
 rtl/el_request_scheduler_pkg.sv | 60 ++++++
 rtl/el_request_scheduler_if.sv | 24 ++
 rtl/el_call_latch.sv | 71 +++++++
 rtl/el_request_scheduler.sv | 157 +++++++++++++++
 tb/tb_el_request_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/el_request_scheduler_pkg.sv
// Shared constants for the elevator request scheduler: motor command
// encodings, FSM state codes, floor numbers and pending-bit layout.
package el_pkg;

  // Motor command encodings
  localparam logic [1:0] AC_UP   = 2'b10;
  localparam logic [1:0] AC_DOWN = 2'b01;
  localparam logic [1:0] AC_STOP = 2'b00;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd1;
  localparam logic [1:0] ST_MOVE_UP   = 2'd2;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd3;

  // Floor numbers as shown on the display
  localparam logic [1:0] FL1 = 2'd1;
  localparam logic [1:0] FL2 = 2'd2;
  localparam logic [1:0] FL3 = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Pending vector layout {D3,D2,U2,U1,F3,F2,F1}
  localparam int P_F1 = 0;
  localparam int P_F2 = 1;
  localparam int P_F3 = 2;
  localparam int P_U1 = 3;
  localparam int P_U2 = 4;
  localparam int P_D2 = 5;
  localparam int P_D3 = 6;

  localparam logic [6:0] CAB_MASK     = 7'b0000111;
  localparam logic [6:0] HALL_UP_MASK = 7'b0011000;
  localparam logic [6:0] HALL_DN_MASK = 7'b1100000;

  // All pending bits (cab and hall) that belong to floor f
  function automatic logic [6:0] floor_mask(input logic [1:0] f);
    logic [6:0] m;
    m = '0;
    case (f)
      FL1: begin
        m[P_F1] = 1'b1;
        m[P_U1] = 1'b1;
      end
      FL2: begin
        m[P_F2] = 1'b1;
        m[P_U2] = 1'b1;
        m[P_D2] = 1'b1;
      end
      FL3: begin
        m[P_F3] = 1'b1;
        m[P_D3] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/el_request_scheduler_if.sv
// Buttons, floor sensors and car outputs of the elevator scheduler.
interface el_request_scheduler_if;
  logic       F1, F2, F3;
  logic       U1, U2;
  logic       D2, D3;
  logic       S1, S2, S3;
  logic [1:0] AC;
  logic [1:0] DISP;
  logic       open;
  logic [6:0] pending;
  logic       busy;

  // Environment side: drives buttons and sensors, observes the car
  modport master (
    output F1, F2, F3, U1, U2, D2, D3, S1, S2, S3,
    input  AC, DISP, open, pending, busy
  );

  // Scheduler side
  modport slave (
    input  F1, F2, F3, U1, U2, D2, D3, S1, S2, S3,
    output AC, DISP, open, pending, busy
  );
endinterface

// File: rtl/el_call_latch.sv
// Pending-call register with per-floor clear, set suppression for the
// floor whose door is open, and floor-relative request summaries.
module el_call_latch
  import el_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [6:0] i_set,
  input  logic       i_clr_en,
  input  logic [1:0] i_clr_floor,
  input  logic       i_supp_en,
  input  logic [1:0] i_supp_floor,
  input  logic [1:0] i_qpos,
  output logic [6:0] o_pending,
  output logic       o_req_at,
  output logic       o_above,
  output logic       o_below,
  output logic       o_stop_up,
  output logic       o_stop_dn
);

  logic [6:0] r_pending;
  logic [6:0] w_set;
  logic [6:0] w_clr;
  logic [6:0] w_qmask;
  logic [3:1] w_req;

  assign w_set   = i_set & ~(i_supp_en ? floor_mask(i_supp_floor) : 7'd0);
  assign w_clr   = i_clr_en ? floor_mask(i_clr_floor) : 7'd0;
  assign w_qmask = floor_mask(i_qpos);

  // Latch new calls; a new press wins over a clear of the same bit
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_set | (r_pending & ~w_clr);
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_req
      assign w_req[gi] = |(r_pending & floor_mask(2'(gi)));
    end
  endgenerate

  // Calls strictly above / below the query floor
  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    case (i_qpos)
      FL1: o_above = w_req[2] | w_req[3];
      FL2: begin
        o_above = w_req[3];
        o_below = w_req[1];
      end
      FL3: o_below = w_req[1] | w_req[2];
      default: begin
        o_above = 1'b0;
        o_below = 1'b0;
      end
    endcase
  end

  assign o_pending = r_pending;
  assign o_req_at  = |(r_pending & w_qmask);
  assign o_stop_up = |(r_pending & w_qmask & (CAB_MASK | HALL_UP_MASK));
  assign o_stop_dn = |(r_pending & w_qmask & (CAB_MASK | HALL_DN_MASK));

endmodule

// File: rtl/el_request_scheduler.sv
// SCAN sequencing controller for a 3-floor car: tracks position from the
// floor sensors, picks direction, drives motor/display/door and times dwell.
module el_request_scheduler
  import el_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 4
) (
  input logic             CLK,
  input logic             RST,
  el_request_scheduler_if.slave bus
);

  localparam logic [7:0] DWELL_LOAD = 8'(DOOR_CYCLES - 1);

  logic [1:0] r_state, w_state_next;
  logic [1:0] r_pos, w_pos_next;
  logic       r_dir, w_dir_next;
  logic [7:0] r_door_cnt, w_door_cnt_next;
  logic [6:0] w_btn;
  logic [2:0] w_sens;
  logic       w_arr_up, w_arr_dn;
  logic [1:0] w_qpos;
  logic       w_enter_door;
  logic       w_own_btn;
  logic       w_go_up;
  logic [6:0] w_pending;
  logic       w_req_at, w_above, w_below, w_stop_up, w_stop_dn;
  logic [1:0] w_ac;

  assign w_btn  = {bus.D3, bus.D2, bus.U2, bus.U1, bus.F3, bus.F2, bus.F1};
  assign w_sens = {bus.S3, bus.S2, bus.S1};

  // Arrival needs the next floor's sensor alone; any other pattern holds
  assign w_arr_up = (r_state == ST_MOVE_UP) &&
                    (((r_pos == FL1) && (w_sens == 3'b010)) ||
                     ((r_pos == FL2) && (w_sens == 3'b100)));
  assign w_arr_dn = (r_state == ST_MOVE_DOWN) &&
                    (((r_pos == FL3) && (w_sens == 3'b010)) ||
                     ((r_pos == FL2) && (w_sens == 3'b001)));

  // Request queries are made for the floor the car is at after this edge
  assign w_qpos = w_arr_up ? (r_pos + 2'd1) :
                  w_arr_dn ? (r_pos - 2'd1) : r_pos;

  assign w_own_btn = |(w_btn & floor_mask(r_pos));
  assign w_go_up   = w_above && ((r_dir == DIR_UP) || !w_below);

  el_call_latch u_call_latch (
    .i_clk        (CLK),
    .i_srst       (RST),
    .i_set        (w_btn),
    .i_clr_en     (w_enter_door),
    .i_clr_floor  (w_qpos),
    .i_supp_en    (r_state == ST_DOOR_OPEN),
    .i_supp_floor (r_pos),
    .i_qpos       (w_qpos),
    .o_pending    (w_pending),
    .o_req_at     (w_req_at),
    .o_above      (w_above),
    .o_below      (w_below),
    .o_stop_up    (w_stop_up),
    .o_stop_dn    (w_stop_dn)
  );

  // Next-state, position, direction and dwell counter decisions
  always_comb begin
    w_state_next    = r_state;
    w_pos_next      = r_pos;
    w_dir_next      = r_dir;
    w_door_cnt_next = r_door_cnt;
    w_enter_door    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_sens)
          3'b001:  w_pos_next = FL1;
          3'b010:  w_pos_next = FL2;
          3'b100:  w_pos_next = FL3;
          default: w_pos_next = r_pos;
        endcase
        if (w_req_at) begin
          w_enter_door = 1'b1;
        end else if (w_go_up) begin
          w_state_next = ST_MOVE_UP;
          w_dir_next   = DIR_UP;
        end else if (w_below) begin
          w_state_next = ST_MOVE_DOWN;
          w_dir_next   = DIR_DOWN;
        end
      end
      ST_DOOR_OPEN: begin
        if (w_own_btn) begin
          w_door_cnt_next = DWELL_LOAD;
        end else if (r_door_cnt == 8'd0) begin
          if (w_go_up) begin
            w_state_next = ST_MOVE_UP;
            w_dir_next   = DIR_UP;
          end else if (w_below) begin
            w_state_next = ST_MOVE_DOWN;
            w_dir_next   = DIR_DOWN;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_door_cnt_next = r_door_cnt - 8'd1;
        end
      end
      ST_MOVE_UP: begin
        if (w_arr_up) begin
          w_pos_next = w_qpos;
          if (w_stop_up || (w_qpos == FL3) || !w_above) w_enter_door = 1'b1;
        end
      end
      ST_MOVE_DOWN: begin
        if (w_arr_dn) begin
          w_pos_next = w_qpos;
          if (w_stop_dn || (w_qpos == FL1) || !w_below) w_enter_door = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_enter_door) begin
      w_state_next    = ST_DOOR_OPEN;
      w_door_cnt_next = DWELL_LOAD;
    end
  end

  // Controller state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_pos      <= FL1;
      r_dir      <= DIR_UP;
      r_door_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_pos      <= w_pos_next;
      r_dir      <= w_dir_next;
      r_door_cnt <= w_door_cnt_next;
    end
  end

  // Motor command decoded from state
  always_comb begin
    case (r_state)
      ST_MOVE_UP:   w_ac = AC_UP;
      ST_MOVE_DOWN: w_ac = AC_DOWN;
      default:      w_ac = AC_STOP;
    endcase
  end

  assign bus.AC      = w_ac;
  assign bus.DISP    = r_pos;
  assign bus.open    = (r_state == ST_DOOR_OPEN);
  assign bus.pending = w_pending;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_el_request_scheduler.sv
// Bench for el_request_scheduler: directed scenarios plus a randomized run
// with a simple car-motion model, checked against a floor-level model.
module tb_el_request_scheduler;

  localparam int DC = 4;
  localparam logic [12:0] IDLE_OUT = {2'b00, 2'd1, 1'b0, 7'd0, 1'b0};

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [6:0] btn  = 7'd0;
  logic [2:0] sens = 3'b001;

  el_request_scheduler_if bus();

  assign bus.F1 = btn[0];
  assign bus.F2 = btn[1];
  assign bus.F3 = btn[2];
  assign bus.U1 = btn[3];
  assign bus.U2 = btn[4];
  assign bus.D2 = btn[5];
  assign bus.D3 = btn[6];
  assign bus.S1 = sens[0];
  assign bus.S2 = sens[1];
  assign bus.S3 = sens[2];

  el_request_scheduler #(.DOOR_CYCLES(DC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (floor-level view) ----------------
  typedef enum int {M_IDLE, M_DOOR, M_UP, M_DN} mst_t;
  mst_t     m_st;
  int       m_pos;
  bit       m_up;
  int       m_cnt;
  bit [6:0] m_pend;

  // floor served by each call button, and its kind (0 cab, 1 up, 2 down)
  function automatic int bfloor(input int i);
    case (i)
      0, 3:    return 1;
      1, 4, 5: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int bkind(input int i);
    case (i)
      0, 1, 2: return 0;
      3, 4:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit calls_at(input int f);
    for (int i = 0; i < 7; i++) if (m_pend[i] && bfloor(i) == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_beyond(input int f, input bit up);
    for (int g = 1; g <= 3; g++)
      if ((up ? (g > f) : (g < f)) && calls_at(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit stop_for(input int f, input int kind);
    for (int i = 0; i < 7; i++)
      if (m_pend[i] && bfloor(i) == f && (bkind(i) == 0 || bkind(i) == kind)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sensor_floor();
    if ($countones(sens) != 1) return 0;
    return sens[0] ? 1 : (sens[1] ? 2 : 3);
  endfunction

  task automatic pick_dir();
    bit up_c, dn_c;
    up_c = calls_beyond(m_pos, 1'b1);
    dn_c = calls_beyond(m_pos, 1'b0);
    if (up_c && (m_up || !dn_c)) begin
      m_st = M_UP;
      m_up = 1'b1;
    end else if (dn_c) begin
      m_st = M_DN;
      m_up = 1'b0;
    end else begin
      m_st = M_IDLE;
    end
  endtask

  task automatic model_step();
    bit [6:0] setb;
    bit [6:0] clr;
    int npos;
    int door_at;
    bit own;
    if (rst) begin
      m_st = M_IDLE; m_pos = 1; m_up = 1'b1; m_cnt = 0; m_pend = '0;
      return;
    end
    setb = btn; clr = '0; npos = m_pos; door_at = 0; own = 1'b0;
    for (int i = 0; i < 7; i++) if (btn[i] && bfloor(i) == m_pos) own = 1'b1;
    if (m_st == M_DOOR)
      for (int i = 0; i < 7; i++) if (bfloor(i) == m_pos) setb[i] = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (sensor_floor() != 0) npos = sensor_floor();
        if (calls_at(m_pos)) door_at = m_pos;
        else pick_dir();
      end
      M_DOOR: begin
        if (own) m_cnt = DC - 1;
        else if (m_cnt == 0) pick_dir();
        else m_cnt--;
      end
      M_UP: begin
        if (m_pos < 3 && sensor_floor() == m_pos + 1) begin
          npos = m_pos + 1;
          if (stop_for(npos, 1) || npos == 3 || !calls_beyond(npos, 1'b1)) door_at = npos;
        end
      end
      M_DN: begin
        if (m_pos > 1 && sensor_floor() == m_pos - 1) begin
          npos = m_pos - 1;
          if (stop_for(npos, 2) || npos == 1 || !calls_beyond(npos, 1'b0)) door_at = npos;
        end
      end
      default: m_st = M_IDLE;
    endcase
    if (door_at != 0) begin
      m_st = M_DOOR;
      m_cnt = DC - 1;
      for (int i = 0; i < 7; i++) if (bfloor(i) == door_at) clr[i] = 1'b1;
    end
    m_pend = setb | (m_pend & ~clr);
    m_pos  = npos;
  endtask

  task automatic compare_model();
    check_eq("model_ac", bus.AC, (m_st == M_UP) ? 2 : ((m_st == M_DN) ? 1 : 0));
    check_eq("model_disp", bus.DISP, m_pos);
    check_eq("model_open", bus.open, (m_st == M_DOOR) ? 1 : 0);
    check_eq("model_pending", bus.pending, m_pend);
    check_eq("model_busy", bus.busy, (m_st != M_IDLE) ? 1 : 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  function automatic logic [12:0] outs();
    return {bus.AC, bus.DISP, bus.open, bus.pending, bus.busy};
  endfunction

  task automatic press(input logic [6:0] b);
    btn = b;
    tick();
    btn = 7'd0;
  endtask

  task automatic step_to(input int f);
    sens = 3'b000;
    tick();
    sens = 3'(1 << (f - 1));
    tick();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      tick();
    end
    check_eq("reach_idle", bus.busy, 0);
  endtask

  task automatic count_open(input string tag);
    int n_open;
    n_open = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.open) n_open++;
      else break;
    end
    check_eq(tag, n_open, DC);
  endtask

  int phys;
  int travel;
  int stops;

  initial begin
    // reset then idle
    rst = 1'b1; btn = '0; sens = 3'b001;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("idle_hold", outs(), IDLE_OUT);
    end
    $display("reset/idle: 20 cycles observed");

    // same-floor call at floor 1
    press(7'h01);
    check_eq("f1_latched", bus.pending, 7'h01);
    tick();
    check_eq("f1_open", bus.open, 1);
    check_eq("f1_cleared", bus.pending, 7'h00);
    count_open("f1_dwell_len");
    check_eq("f1_back_idle", bus.busy, 0);
    $display("same-floor call at floor 1 done");

    // pass-through from 1 to 3
    press(7'h04);
    check_eq("f3_latched", bus.pending, 7'h04);
    tick();
    check_eq("pt_up", bus.AC, 2'b10);
    step_to(2);
    check_eq("pt_disp2", bus.DISP, 2);
    check_eq("pt_still_up", bus.AC, 2'b10);
    step_to(3);
    check_eq("pt_stop", bus.AC, 2'b00);
    check_eq("pt_open", bus.open, 1);
    check_eq("pt_clear", bus.pending, 7'h00);
    wait_idle();
    $display("pass-through 1->3 done");

    // return to floor 1, passing 2
    press(7'h01);
    tick();
    check_eq("ret_down", bus.AC, 2'b01);
    step_to(2);
    check_eq("ret_pass2", bus.AC, 2'b01);
    step_to(1);
    check_eq("ret_open1", bus.open, 1);
    check_eq("ret_disp1", bus.DISP, 1);
    wait_idle();
    $display("return 3->1 done");

    // SCAN hold: D2 while heading up to F3
    press(7'h04);
    tick();
    check_eq("scan_up", bus.AC, 2'b10);
    press(7'h20);
    check_eq("scan_pend", bus.pending, 7'h24);
    step_to(2);
    check_eq("scan_pass_disp", bus.DISP, 2);
    check_eq("scan_pass_ac", bus.AC, 2'b10);
    step_to(3);
    check_eq("scan_open3", bus.open, 1);
    check_eq("scan_pend3", bus.pending, 7'h20);
    for (int k = 0; k < 20; k++) begin
      if (bus.AC == 2'b01) break;
      tick();
    end
    check_eq("scan_reverse", bus.AC, 2'b01);
    step_to(2);
    check_eq("scan_open2", bus.open, 1);
    check_eq("scan_clr_d2", bus.pending, 7'h00);
    wait_idle();
    $display("SCAN hold scenario done");

    // dwell restart at floor 2
    press(7'h02);
    check_eq("dw_latched", bus.pending, 7'h02);
    tick();
    check_eq("dw_open", bus.open, 1);
    tick(); tick();
    press(7'h02);
    check_eq("dw_still_open", bus.open, 1);
    check_eq("dw_not_latched", bus.pending, 7'h00);
    count_open("dw_restart_len");
    wait_idle();
    $display("dwell restart done");

    // reset mid-move down from 3
    press(7'h04);
    tick();
    step_to(3);
    wait_idle();
    press(7'h01);
    tick();
    check_eq("md_down", bus.AC, 2'b01);
    sens = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("md_reset", outs(), IDLE_OUT);
    sens = 3'b010;
    tick();
    check_eq("md_resync", bus.DISP, 2);
    press(7'h01);
    tick();
    check_eq("md_after", bus.AC, 2'b01);
    step_to(1);
    wait_idle();
    $display("reset mid-move done");

    // two sensors at once is not an arrival
    press(7'h02);
    tick();
    check_eq("ms_up", bus.AC, 2'b10);
    sens = 3'b011;
    tick();
    check_eq("ms_hold_disp", bus.DISP, 1);
    check_eq("ms_hold_ac", bus.AC, 2'b10);
    sens = 3'b010;
    tick();
    check_eq("ms_arrive", bus.DISP, 2);
    check_eq("ms_open", bus.open, 1);
    wait_idle();
    $display("multi-sensor hold done");

    // randomized traffic with a simple motion model
    phys = 2; travel = 0; stops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      btn = 7'd0;
      if ($urandom_range(0, 5) == 0) btn = 7'(1 << $urandom_range(0, 6));
      if (m_st == M_UP || m_st == M_DN) begin
        if (travel == 0) travel = $urandom_range(2, 5);
        travel--;
        if (travel == 0) phys = phys + ((m_st == M_UP) ? 1 : -1);
      end
      if (travel == 0) sens = 3'(1 << (phys - 1));
      else sens = ($urandom_range(0, 3) == 0) ? 3'(1 << (phys - 1)) : 3'b000;
      begin
        bit was_door;
        was_door = (m_st == M_DOOR);
        tick();
        if (m_st == M_DOOR && !was_door) begin
          stops++;
          $display("random stop %0d at floor %0d, cycle %0d", stops, m_pos, cyc);
        end
      end
    end
    btn = 7'd0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
